// File: rtl/exec_controller_if.sv
// Datapath-facing signal bundle for exec_controller: run control, counter snapshots, readout.
// The master side drives the inputs, and the controller connects to the slave side.
interface exec_controller_if #(
    parameter int CNT_W = 32
);
    logic             stepping_flag;
    logic             next_instr;
    logic             instr_retired;
    logic             cpu_finish;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] arith_cnt;
    logic [CNT_W-1:0] mem_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic             snapshot_req;
    logic [2:0]       sel;
    logic             cpu_en;
    logic             halted;
    logic [2:0]       state;
    logic [31:0]      step_count;
    logic [CNT_W-1:0] snap_data;
    logic             snap_valid;

    modport master (
        output stepping_flag, next_instr, instr_retired, cpu_finish,
        output stall_cnt, arith_cnt, mem_cnt, cycle_cnt, instr_cnt,
        output snapshot_req, sel,
        input  cpu_en, halted, state, step_count, snap_data, snap_valid
    );

    modport slave (
        input  stepping_flag, next_instr, instr_retired, cpu_finish,
        input  stall_cnt, arith_cnt, mem_cnt, cycle_cnt, instr_cnt,
        input  snapshot_req, sel,
        output cpu_en, halted, state, step_count, snap_data, snap_valid
    );
endinterface

// File: rtl/exec_controller.sv
// Run/step/pause controller for the datapath, with a debounced step button and counter snapshots.
// Timing: a button press is seen 2+DEBOUNCE_CYCLES cycles after the raw rise, and cpu_en follows the registered state.
module exec_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic               clkFPGA,
    input  logic               rst,
    exec_controller_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1, r_sync2;
    logic             r_db_level, r_db_level_d;
    logic [DB_W-1:0]  r_db_cnt;
    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_step_count;
    logic             r_snap_valid;
    logic [CNT_W-1:0] r_snap_stall, r_snap_arith, r_snap_mem, r_snap_cycle, r_snap_instr;
    logic [CNT_W-1:0] w_snap_data;
    logic             w_press;
    logic             w_step_inc;
    logic             w_snap_take;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive sample that differs from it.
    always_ff @(posedge clkFPGA) begin
        if (!rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_db_level   <= 1'b0;
            r_db_level_d <= 1'b0;
            r_db_cnt     <= '0;
        end else begin
            r_sync1      <= bus.next_instr;
            r_sync2      <= r_sync1;
            r_db_level_d <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db_level & ~r_db_level_d;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // A coincident cpu_finish swallows the press here too.
                if (!bus.cpu_finish && w_press)
                    w_next = bus.stepping_flag ? STEP : RUN;
            end
            RUN: begin
                if (bus.cpu_finish)          w_next = DONE;
                else if (bus.stepping_flag)  w_next = PAUSE;
            end
            STEP: begin
                if (bus.cpu_finish)          w_next = DONE;
                else if (bus.instr_retired)  w_next = PAUSE;
            end
            PAUSE: begin
                if (bus.cpu_finish)          w_next = DONE;
                else if (w_press)            w_next = bus.stepping_flag ? STEP : RUN;
            end
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    assign w_step_inc  = (r_state == STEP) && bus.instr_retired;
    assign w_snap_take = bus.snapshot_req || ((w_next == DONE) && (r_state != DONE));

    always_ff @(posedge clkFPGA) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_step_count <= '0;
            r_snap_valid <= 1'b0;
            r_snap_stall <= '0;
            r_snap_arith <= '0;
            r_snap_mem   <= '0;
            r_snap_cycle <= '0;
            r_snap_instr <= '0;
        end else begin
            r_state <= w_next;
            if (w_step_inc && (r_step_count != 32'hFFFF_FFFF))
                r_step_count <= r_step_count + 32'd1;
            if (w_snap_take) begin
                r_snap_stall <= bus.stall_cnt;
                r_snap_arith <= bus.arith_cnt;
                r_snap_mem   <= bus.mem_cnt;
                r_snap_cycle <= bus.cycle_cnt;
                r_snap_instr <= bus.instr_cnt;
                r_snap_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_snap_data = '0;
        case (bus.sel)
            3'd0:    w_snap_data = r_snap_stall;
            3'd1:    w_snap_data = r_snap_arith;
            3'd2:    w_snap_data = r_snap_mem;
            3'd3:    w_snap_data = r_snap_cycle;
            3'd4:    w_snap_data = r_snap_instr;
            3'd5:    w_snap_data = CNT_W'(r_step_count);
            3'd6:    w_snap_data = CNT_W'(r_state);
            default: w_snap_data = '0;
        endcase
    end

    assign bus.cpu_en     = (r_state == RUN) || (r_state == STEP);
    assign bus.halted     = (r_state == DONE);
    assign bus.state      = r_state;
    assign bus.step_count = r_step_count;
    assign bus.snap_valid = r_snap_valid;
    assign bus.snap_data  = w_snap_data;
endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized cycles needed to accept a new next_instr level.
REQ-002 Parameter CNT_W, default 32, is the width of every performance counter input and of snap_data.
REQ-003 clkFPGA  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 stepping_flag  input  1  1 = single-step mode, 0 = free-run mode.
REQ-006 next_instr  input  1  raw, asynchronous, active-high push-button.
REQ-007 instr_retired  input  1  one-cycle pulse from the datapath per completed instruction.
REQ-008 cpu_finish  input  1  datapath program-end indication, level or pulse.
REQ-009 stall_cnt, arith_cnt, mem_cnt, cycle_cnt, instr_cnt  input  CNT_W each  live datapath counters.
REQ-010 snapshot_req  input  1  one-cycle request to latch all five counters.
REQ-011 sel  input  3  readout select.
REQ-012 cpu_en  output  1  clock enable to the datapath.
REQ-013 halted  output  1  high in DONE only.
REQ-014 state  output  3  current FSM encoding.
REQ-015 step_count  output  32  number of instructions retired in STEP state.
REQ-016 snap_data  output  CNT_W  selected snapshot or status word.
REQ-017 snap_valid  output  1  at least one snapshot has been taken since reset.

Function
REQ-018 next_instr SHALL pass through a 2-flop synchronizer, then the debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-019 A one-cycle press pulse SHALL be generated on each 0->1 transition of the debounced level; raw rise at cycle 0 with a stable input gives press at cycle 2+DEBOUNCE_CYCLES.
REQ-020 The FSM states and encodings SHALL be IDLE=0, RUN=1, STEP=2, PAUSE=3, DONE=4; state is registered and drives the state output directly.
REQ-021 IDLE: cpu_en=0; on press, go to STEP if stepping_flag=1, else go to RUN.
REQ-022 RUN: cpu_en=1; on cpu_finish go to DONE; else if stepping_flag=1 go to PAUSE; a press is ignored.
REQ-023 STEP: cpu_en=1; on instr_retired go to PAUSE and increment step_count, saturating at 2^32-1; on cpu_finish go to DONE.
REQ-024 PAUSE: cpu_en=0; on cpu_finish go to DONE; on press, go to STEP if stepping_flag=1, else go to RUN.
REQ-025 DONE: cpu_en=0 and halted=1; DONE SHALL be exited only by reset.
REQ-026 cpu_en SHALL be a pure decode of the registered state, so it falls in the cycle after the instr_retired or cpu_finish sample.
REQ-027 If cpu_finish and instr_retired coincide in STEP: go to DONE and still increment step_count.
REQ-028 cpu_finish SHALL have priority over a press and over a stepping_flag change in every state.
REQ-029 On snapshot_req, or on any transition into DONE, all five counter inputs SHALL be latched simultaneously; snap_valid SHALL rise the next cycle and stay high until reset.
REQ-030 If snapshot_req coincides with DONE entry, exactly one snapshot of the current-cycle values SHALL be taken.
REQ-031 snap_data SHALL be a combinational mux on sel:
- 0 = stall, 1 = arith, 2 = mem, 3 = cycle, 4 = instr snapshots
- 5 = step_count, zero-extended
- 6 = state, zero-extended
- 7 = 0

Reset
REQ-032 While rst=0 at a clock edge: state=IDLE, cpu_en=0, halted=0, step_count=0, snap_valid=0, all snapshots 0, synchronizer and debounced level 0.
REQ-033 Reset SHALL take effect from any state, including mid-STEP and DONE; a button held through reset release yields one press 2+DEBOUNCE_CYCLES cycles after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Reset, stepping_flag=1, hold next_instr 10 cycles -> press at cycle 6; STEP with cpu_en=1; instr_retired pulse -> PAUSE, cpu_en=0 next cycle, step_count=1.
REQ-035 Bounce next_instr 1,0,1,0 (1-cycle glitches) -> no press, state stays IDLE.
REQ-036 stepping_flag=0, press -> RUN; raise stepping_flag -> PAUSE; clear it and press -> RUN; cpu_finish -> DONE, halted=1, snap_valid=1, sel=3 returns the cycle_cnt value at DONE entry.
REQ-037 In STEP, drive instr_retired and cpu_finish in the same cycle -> DONE, step_count incremented by 1.
REQ-038 stall_cnt=0x10, snapshot_req pulse, then stall_cnt=0x20 -> sel=0 reads 0x10; sel=7 reads 0.
REQ-039 Assert rst=0 for one cycle mid-STEP -> next cycle IDLE, cpu_en=0, step_count=0, snap_valid=0.
